max_unpool_pair: RTL
====================

Name: max_unpool_pair

Overview:
- Decoder-side counterpart of the 1x2 max-pool compare stage.
- Takes a stream of pooled 16-bit maxima plus 1-bit argmax indices.
- Writes each value back to its original slot of a 32-bit pair word in the decoder's output BRAM.
- Non-max slot is zero-filled (unpool mode) or duplicated (nearest-neighbour mode). One frame of NUM_ELEMS pooled elements is processed per start pulse.

Parameters:
- NUM_ELEMS, 1024, pooled elements per frame (= output pair words written per frame); must be >= 1.
- ADDR_WIDTH, 10, output BRAM word-address width; 2**ADDR_WIDTH >= NUM_ELEMS.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle
- mode  in  1  0 = zero-fill unpool, 1 = duplicate; sampled only on accepted start
- in_valid  in  1  pooled element present
- in_data  in  16  pooled max value
- in_idx  in  1  argmax: 0 = lower half [15:0] was max, 1 = upper half [31:16]
- in_ready  out  1  block accepts element this cycle
- Output_write_data  out  32  pair word to BRAM
- Output_BRAM_we  out  4  byte write enables
- Output_BRAM_addr  out  ADDR_WIDTH  word address
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last word written

Behaviour:
- Reset values: Output_write_data=0, Output_BRAM_we=0, Output_BRAM_addr=0, in_ready=0, busy=0, done=0, state=IDLE, element count=0, latched mode=0.
- rst has priority over every other input in every state. Reset mid-frame abandons the frame, with no done pulse. Words already written stay in BRAM.
- States:
  - IDLE: in_ready=0, busy=0. start=1 -> latch mode, clear count, go to RUN.
  - RUN: in_ready=1, busy=1. Accept when in_valid && in_ready. On the accept that makes count = NUM_ELEMS, go to FLUSH.
  - FLUSH: in_ready=0, busy=1. The last write is issued this cycle. Next state is DONE.
  - DONE: done=1 for exactly one cycle, busy=0. Next state is IDLE.
- start outside IDLE is ignored. start is honoured in the same cycle the block enters IDLE from DONE only on the following cycle; no back-to-back frame in the DONE cycle.
- Latency: accept at cycle N -> Output_BRAM_we=4'hF with data/address at cycle N+1 (one register stage). No backpressure on the BRAM side.
- Output_BRAM_we=0 in every cycle with no accept in the previous cycle. Gaps in in_valid produce gaps in writes; the address does not advance.
- Data formation, with v = in_data:
  - mode 0, idx 0: {16'h0000, v}
  - mode 0, idx 1: {v, 16'h0000}
  - mode 1, either idx: {v, v}
- Output_BRAM_addr = number of elements accepted before this one (0 .. NUM_ELEMS-1), starting at 0 each frame. The counter never wraps within a frame. After the frame the address holds its last value until the next start.
- Output_write_data holds its last value when we=0.
- Inputs while in_ready=0 are ignored; nothing is written for them.
- Counter width is $clog2(NUM_ELEMS+1) so the NUM_ELEMS comparison does not overflow.

Decomposition:
- Shared package (pool_pkg): state encoding localparams (IDLE, RUN, FLUSH, DONE); MODE_ZERO=0, MODE_DUP=1; IDX_LO=0, IDX_HI=1; PAIR_W=32, ELEM_W=16.
- One natural sub-module: unpool_pair_format. Combinational mapping of (mode, idx, data) to the 32-bit word; reused by the bench as its reference model.
- FSM, counter and output register stay in max_unpool_pair.

Test Plan:
- Reset, then start with mode=0, NUM_ELEMS=4, continuous valid, data 0x1111/0x2222/0x3333/0x4444, idx 0/1/1/0:
  - Writes at addr 0..3: 0x00001111, 0x22220000, 0x33330000, 0x00004444, each one cycle after accept.
  - done pulses exactly once, two cycles after the last accept.
- mode=1, data 0xABCD idx=1 -> word 0xABCDABCD at addr 0.
  - Raise mode after start, mid-frame: later words still use the latched mode=1.
- in_valid toggling 1,0,0,1 with data 0x0005, 0x0006:
  - Exactly two writes, addr 0 then 1.
  - we=0 during the gap; address unchanged during the gap.
- start pulsed during RUN and during DONE -> ignored. Count and address unaffected; single done per frame.
- Assert rst after 2 of 4 elements:
  - Next cycle all outputs are at reset values; no done.
  - A new start restarts at addr 0.
- NUM_ELEMS=1: start, one element 0x7FFF idx 0 -> single write 0x00007FFF at addr 0, then done. in_ready low after the accept.

Source files
------------

// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pool_pkg
//  Description : Shared types and constants for the 1x2 max-unpool decoder
//                stage (FSM states, mode/index encodings, word widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package pool_pkg;

    // Frame controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Non-max slot handling
    localparam logic MODE_ZERO = 1'b0;
    localparam logic MODE_DUP  = 1'b1;

    // Argmax slot within the pair word
    localparam logic IDX_LO = 1'b0;
    localparam logic IDX_HI = 1'b1;

    localparam int PAIR_W = 32;
    localparam int ELEM_W = 16;

endpackage : pool_pkg
`default_nettype wire

// File: rtl/unpool_pair_format.sv
`default_nettype none
// ============================================================================
//  Module      : unpool_pair_format
//  Description : Maps a pooled maximum, its argmax slot and the fill mode to
//                the reconstructed 32-bit pair word.
//  Revision    : 1.0 - initial release
// ============================================================================
module unpool_pair_format
    import pool_pkg::*;
(
    input  logic              i_mode,
    input  logic              i_idx,
    input  logic [ELEM_W-1:0] i_data,
    output logic [PAIR_W-1:0] o_word
);

    // Place the value in its original slot; the other slot is a copy or zero
    always_comb begin
        o_word = '0;
        if (i_mode == MODE_DUP) begin
            o_word = {i_data, i_data};
        end else if (i_idx == IDX_HI) begin
            o_word = {i_data, {ELEM_W{1'b0}}};
        end else if (i_idx == IDX_LO) begin
            o_word = {{ELEM_W{1'b0}}, i_data};
        end
    end

endmodule : unpool_pair_format
`default_nettype wire

// File: rtl/max_unpool_pair.sv
`default_nettype none
// ============================================================================
//  Module      : max_unpool_pair
//  Description : Decoder-side 1x2 max-unpool. Consumes one frame of pooled
//                16-bit maxima with argmax bits per start pulse and writes one
//                32-bit pair word per element into the output BRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module max_unpool_pair
    import pool_pkg::*;
#(
    parameter int NUM_ELEMS  = 1024,
    parameter int ADDR_WIDTH = 10
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  in_valid,
    input  logic [ELEM_W-1:0]     in_data,
    input  logic                  in_idx,
    output logic                  in_ready,
    output logic [PAIR_W-1:0]     Output_write_data,
    output logic [3:0]            Output_BRAM_we,
    output logic [ADDR_WIDTH-1:0] Output_BRAM_addr,
    output logic                  busy,
    output logic                  done
);

    // One extra bit so the count can reach NUM_ELEMS itself
    localparam int CNT_W = $clog2(NUM_ELEMS + 1);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(NUM_ELEMS);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    state_t                r_state_q, w_state_d;
    logic [CNT_W-1:0]      r_count_q, w_count_d;
    logic                  r_mode_q,  w_mode_d;
    logic [PAIR_W-1:0]     r_wdata_q, w_wdata_d;
    logic [3:0]            r_we_q,    w_we_d;
    logic [ADDR_WIDTH-1:0] r_addr_q,  w_addr_d;

    logic [PAIR_W-1:0]     w_word;
    logic [ADDR_WIDTH-1:0] w_count_addr;
    logic [CNT_W-1:0]      w_count_inc;
    logic                  w_ready;
    logic                  w_busy;
    logic                  w_done;

    unpool_pair_format u_format (
        .i_mode (r_mode_q),
        .i_idx  (in_idx),
        .i_data (in_data),
        .o_word (w_word)
    );

    // Element count never exceeds NUM_ELEMS-1 when used as an address, so
    // resizing to the BRAM address width is lossless.
    generate
        if (CNT_W > ADDR_WIDTH) begin : g_addr_trunc
            assign w_count_addr = r_count_q[ADDR_WIDTH-1:0];
        end else if (CNT_W == ADDR_WIDTH) begin : g_addr_same
            assign w_count_addr = r_count_q;
        end else begin : g_addr_ext
            assign w_count_addr = {{(ADDR_WIDTH-CNT_W){1'b0}}, r_count_q};
        end
    endgenerate

    assign w_count_inc = r_count_q + c_one;

    // Next-state, accept handling and write-port formation
    always_comb begin
        w_state_d = r_state_q;
        w_count_d = r_count_q;
        w_mode_d  = r_mode_q;
        w_wdata_d = r_wdata_q;
        w_addr_d  = r_addr_q;
        w_we_d    = 4'h0;
        w_ready   = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (start) begin
                    w_mode_d  = mode;
                    w_count_d = '0;
                    w_state_d = RUN;
                end
            end
            RUN: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (in_valid) begin
                    w_we_d    = 4'hF;
                    w_wdata_d = w_word;
                    w_addr_d  = w_count_addr;
                    w_count_d = w_count_inc;
                    if (w_count_inc == c_last) begin
                        w_state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                w_busy    = 1'b1;
                w_state_d = DONE;
            end
            DONE: begin
                w_done    = 1'b1;
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // State, counter and BRAM write-port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_count_q <= '0;
            r_mode_q  <= MODE_ZERO;
            r_wdata_q <= '0;
            r_we_q    <= 4'h0;
            r_addr_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_count_q <= w_count_d;
            r_mode_q  <= w_mode_d;
            r_wdata_q <= w_wdata_d;
            r_we_q    <= w_we_d;
            r_addr_q  <= w_addr_d;
        end
    end

    assign in_ready          = w_ready;
    assign busy              = w_busy;
    assign done              = w_done;
    assign Output_write_data = r_wdata_q;
    assign Output_BRAM_we    = r_we_q;
    assign Output_BRAM_addr  = r_addr_q;

endmodule : max_unpool_pair
`default_nettype wire
